// File: rtl/cache_dm_ctrl_pkg.sv
// Shared types and width helpers for the direct-mapped read cache.
// Any module or interface that needs them imports this package.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FILL,
        RESP
    } state_t;

    // Upper bounds for the generic word-select helper; real widths are truncated by the caller.
    localparam int MAX_LINE_W = 4096;
    localparam int MAX_DATA_W = 1024;

    function automatic int calc_off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int index_w, input int words);
        return addr_w - index_w - $clog2(words);
    endfunction

    function automatic int calc_line_w(input int data_w, input int words);
        return data_w * words;
    endfunction

    // Word 0 sits in the MSBs of a line; the result is LSB-aligned.
    function automatic logic [MAX_DATA_W-1:0] line_word(input logic [MAX_LINE_W-1:0] line,
                                                        input int w, input int words,
                                                        input int data_w);
        logic [MAX_LINE_W-1:0] shifted;
        shifted = line >> ((words - 1 - w) * data_w);
        return shifted[MAX_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/cache_dm_ctrl_if.sv
// Load-port, memory-fill and statistics signals of the cache.
// The cache uses the slave modport; the datapath/memory side uses master.
interface cache_dm_ctrl_if
    import cache_pkg::*;
#(
    parameter int ADDR_W         = 15,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 16
);
    localparam int OFF_W  = calc_off_w(WORDS_PER_LINE);
    localparam int LINE_W = calc_line_w(DATA_W, WORDS_PER_LINE);

    logic                    req_valid;
    logic [ADDR_W-1:0]       req_addr;
    logic                    req_ready;
    logic                    flush;
    logic                    resp_valid;
    logic [DATA_W-1:0]       resp_data;
    logic                    resp_hit;
    logic                    mem_req;
    logic [ADDR_W-OFF_W-1:0] mem_addr;
    logic                    mem_ack;
    logic [LINE_W-1:0]       mem_line;
    logic [CNT_W-1:0]        hit_cnt;
    logic [CNT_W-1:0]        miss_cnt;

    modport master (
        output req_valid, req_addr, flush, mem_ack, mem_line,
        input  req_ready, resp_valid, resp_data, resp_hit, mem_req, mem_addr,
               hit_cnt, miss_cnt
    );

    modport slave (
        input  req_valid, req_addr, flush, mem_ack, mem_line,
        output req_ready, resp_valid, resp_data, resp_hit, mem_req, mem_addr,
               hit_cnt, miss_cnt
    );

endinterface

// File: rtl/cache_dm_ctrl_line_store.sv
// Valid/tag/data storage for the direct-mapped cache: one combinational read port,
// one write port and a single-cycle clear of every valid bit.
module cache_line_store #(
    parameter int INDEX_W = 10,
    parameter int TAG_W   = 3,
    parameter int LINE_W  = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_all,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_line
);
    localparam int DEPTH = 2 ** INDEX_W;

    logic [DEPTH-1:0]  valid_reg;
    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [LINE_W-1:0] data_mem [DEPTH];

    // Only the valid bits are reset; tag and data contents are don't-care until filled.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (clear_all) begin
                    valid_reg[gi] <= 1'b0;
                end else if (we && (wr_index == INDEX_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid_reg[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/cache_dm_ctrl.sv
// Direct-mapped read cache with a blocking miss FSM: hits answered from the line store,
// misses fetch a full line over mem_req/mem_ack before answering.
module cache_dm_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W         = 15,
    parameter int INDEX_W        = 10,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 16
) (
    input logic            clk,
    input logic            rst,
    cache_dm_ctrl_if.slave bus
);
    localparam int OFF_W  = calc_off_w(WORDS_PER_LINE);
    localparam int TAG_W  = calc_tag_w(ADDR_W, INDEX_W, WORDS_PER_LINE);
    localparam int LINE_W = calc_line_w(DATA_W, WORDS_PER_LINE);

    state_t                  state_reg;
    logic                    armed_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic                    resp_valid_reg;
    logic [DATA_W-1:0]       resp_data_reg;
    logic                    resp_hit_reg;
    logic                    mem_req_reg;
    logic [ADDR_W-OFF_W-1:0] mem_addr_reg;
    logic [CNT_W-1:0]        hit_cnt_reg;
    logic [CNT_W-1:0]        miss_cnt_reg;

    logic [TAG_W-1:0]   tag_cur;
    logic [INDEX_W-1:0] index_cur;
    logic [OFF_W-1:0]   off_cur;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [LINE_W-1:0]  rd_line;
    logic               hit;
    logic               idle;
    logic               accept;
    logic               fill_we;
    logic [DATA_W-1:0]  hit_word;
    logic [DATA_W-1:0]  fill_word;

    assign {tag_cur, index_cur, off_cur} = addr_reg;

    assign idle      = (state_reg == IDLE);
    assign accept    = idle && armed_reg && bus.req_valid && !bus.flush;
    assign fill_we   = (state_reg == FILL) && bus.mem_ack;
    assign hit       = rd_valid && (rd_tag == tag_cur);
    assign hit_word  = DATA_W'(line_word(MAX_LINE_W'(rd_line), int'(off_cur),
                                         WORDS_PER_LINE, DATA_W));
    assign fill_word = DATA_W'(line_word(MAX_LINE_W'(bus.mem_line), int'(off_cur),
                                         WORDS_PER_LINE, DATA_W));

    cache_line_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .LINE_W  (LINE_W)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .clear_all (idle && bus.flush),
        .rd_index  (index_cur),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .we        (fill_we),
        .wr_index  (index_cur),
        .wr_tag    (tag_cur),
        .wr_line   (bus.mem_line)
    );

    // armed_reg keeps req_ready low until the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            armed_reg      <= 1'b0;
            addr_reg       <= '0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
            resp_hit_reg   <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            hit_cnt_reg    <= '0;
            miss_cnt_reg   <= '0;
        end else begin
            armed_reg      <= 1'b1;
            resp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg  <= bus.req_addr;
                        state_reg <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_data_reg <= hit_word;
                        resp_hit_reg  <= 1'b1;
                        if (hit_cnt_reg != {CNT_W{1'b1}}) begin
                            hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
                        end
                        state_reg <= RESP;
                    end else begin
                        if (miss_cnt_reg != {CNT_W{1'b1}}) begin
                            miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
                        end
                        mem_req_reg  <= 1'b1;
                        mem_addr_reg <= {tag_cur, index_cur};
                        state_reg    <= FILL;
                    end
                end
                FILL: begin
                    if (bus.mem_ack) begin
                        mem_req_reg   <= 1'b0;
                        resp_data_reg <= fill_word;
                        resp_hit_reg  <= 1'b0;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_reg <= 1'b1;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = idle && armed_reg && !bus.flush;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_data  = resp_data_reg;
    assign bus.resp_hit   = resp_hit_reg;
    assign bus.mem_req    = mem_req_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.hit_cnt    = hit_cnt_reg;
    assign bus.miss_cnt   = miss_cnt_reg;

endmodule

// File: tb/tb_cache_dm_ctrl.sv
// Scoreboard bench for cache_dm_ctrl: a word-level memory and line-presence model predict
// each response; a second instance with 2-bit counters shares the stimulus to show saturation.
`timescale 1ns/1ps
module tb_cache_dm_ctrl;
    localparam int ADDR_W = 15;
    localparam int INDEX_W = 10;
    localparam int WPL = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W = 16;
    localparam int LINE_W = DATA_W * WPL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_dm_ctrl_if #(.ADDR_W(ADDR_W), .WORDS_PER_LINE(WPL), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus();
    cache_dm_ctrl_if #(.ADDR_W(ADDR_W), .WORDS_PER_LINE(WPL), .DATA_W(DATA_W), .CNT_W(2)) bus_s();

    assign bus_s.req_valid = bus.req_valid;
    assign bus_s.req_addr  = bus.req_addr;
    assign bus_s.flush     = bus.flush;
    assign bus_s.mem_ack   = bus.mem_ack;
    assign bus_s.mem_line  = bus.mem_line;

    cache_dm_ctrl #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .WORDS_PER_LINE(WPL),
                    .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
    cache_dm_ctrl #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .WORDS_PER_LINE(WPL),
                    .DATA_W(DATA_W), .CNT_W(2)) dut_sat (.clk(clk), .rst(rst), .bus(bus_s));

    typedef struct {
        logic [31:0] data;
        bit          hit;
        int unsigned hits;
        int unsigned misses;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [12:0] fill_q[$];
    logic [31:0] mem_pre[int];
    bit          m_valid[1024];
    logic [2:0]  m_tag[1024];
    int unsigned m_hits = 0;
    int unsigned m_misses = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          hold_ack = 1'b0;
    bit          late_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_word(input int a);
        if (mem_pre.exists(a)) return mem_pre[a];
        return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [LINE_W-1:0] build_line(input int la);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int w = 0; w < WPL; w++) l[LINE_W-1-w*DATA_W -: DATA_W] = mem_word(la * WPL + w);
        return l;
    endfunction

    function automatic int unsigned sat3(input int unsigned v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
    endtask

    task automatic issue(input logic [14:0] addr);
        int   n;
        int   idx;
        exp_t e;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        #1;
        n = 0;
        while (!bus.req_ready) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL req_ready_timeout actual=0 required=1 addr=%0h", addr);
                bus.req_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        idx   = int'(addr[11:2]);
        e.hit = m_valid[idx] && (m_tag[idx] == addr[14:12]);
        if (e.hit) begin
            m_hits++;
        end else begin
            m_misses++;
            fill_q.push_back(addr[14:2]);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = addr[14:12];
        end
        e.data   = mem_word(int'(addr));
        e.hits   = m_hits;
        e.misses = m_misses;
        e.cyc    = cyc;
        exp_q.push_back(e);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic flush_pulse(input logic [14:0] addr);
        @(negedge clk);
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        #1;
        check("req_ready_during_flush", bus.req_ready, 0);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every response strobe is matched against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_resp actual=resp_valid=1 data=%0h required=no response",
                             bus.resp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", bus.resp_data, e.data);
                    check("resp_hit", bus.resp_hit, e.hit);
                    check("hit_cnt", bus.hit_cnt, e.hits);
                    check("miss_cnt", bus.miss_cnt, e.misses);
                    check("sat_hit_cnt", bus_s.hit_cnt, sat3(e.hits));
                    check("sat_miss_cnt", bus_s.miss_cnt, sat3(e.misses));
                    if (e.hit) check("hit_latency", cyc - e.cyc, 2);
                end
            end
        end
    end

    // Memory responder: checks each fetch address, then acks after a random delay.
    initial begin
        logic [12:0] la;
        bus.mem_ack  = 1'b0;
        bus.mem_line = '0;
        forever begin
            @(negedge clk);
            if (late_ack) begin
                bus.mem_ack  = 1'b1;
                bus.mem_line = build_line(13'h1abc);
                late_ack     = 1'b0;
                repeat (2) @(negedge clk);
                bus.mem_ack = 1'b0;
            end else if (!rst && bus.mem_req && !hold_ack) begin
                if (fill_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_req actual=mem_req=1 addr=%0h required=0", bus.mem_addr);
                end else begin
                    la = fill_q.pop_front();
                    check("mem_addr", bus.mem_addr, la);
                end
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    check("mem_req_held", bus.mem_req, 1);
                end
                bus.mem_ack  = 1'b1;
                bus.mem_line = build_line(int'(bus.mem_addr));
                @(negedge clk);
                bus.mem_ack = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [14:0] a;
        int          n;
        int          spurious;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        model_clear();
        mem_pre[15'h5014] = 32'h0000_0011;
        mem_pre[15'h5015] = 32'h0000_0022;
        mem_pre[15'h5016] = 32'h0000_0033;
        mem_pre[15'h5017] = 32'h0000_0044;

        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_resp_hit", bus.resp_hit, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_hit_cnt", bus.hit_cnt, 0);
        check("rst_miss_cnt", bus.miss_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed: cold miss, hit, conflict miss, old tag misses again.
        issue(15'h5016);
        issue(15'h5014);
        issue(15'h2014);
        issue(15'h5014);
        drain();

        // Flush beats a simultaneous request; the line must then miss.
        flush_pulse(15'h5016);
        issue(15'h5016);
        drain();

        // Random traffic over a few indices so hits and conflicts both occur.
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                drain();
                flush_pulse(15'($urandom));
            end
            case ($urandom_range(0, 4))
                0: n = 0;
                1: n = 1;
                2: n = 2;
                3: n = 5;
                default: n = 1023;
            endcase
            a = {3'($urandom_range(0, 7)), 10'(n), 2'($urandom_range(0, 3))};
            issue(a);
        end
        drain();

        // Reset in the middle of a fill, then a late ack with nothing pending.
        flush_pulse(15'h0000);
        hold_ack = 1'b1;
        issue(15'h7abc);
        n = 0;
        while (!bus.mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fill_mem_req_up", bus.mem_req, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_fill_mem_req", bus.mem_req, 0);
        check("rst_fill_hit_cnt", bus.hit_cnt, 0);
        check("rst_fill_miss_cnt", bus.miss_cnt, 0);
        check("rst_fill_req_ready", bus.req_ready, 0);
        exp_q.delete();
        fill_q.delete();
        model_clear();
        m_hits   = 0;
        m_misses = 0;
        @(negedge clk);
        rst      = 1'b0;
        hold_ack = 1'b0;
        late_ack = 1'b1;
        spurious = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.resp_valid) spurious++;
        end
        check("late_ack_no_resp", spurious, 0);

        issue(15'h5016);
        issue(15'h5017);
        issue(15'h7abc);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
